// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//   Memory-access stage plus MEM/WB pipeline register of a 16-bit pipeline.
//   Issues data-memory requests for loads/stores coming out of EX/MEM.
//   Stalls the upstream pipe while memory is not ready. Abandons an access
//   after TIMEOUT wait cycles and flags err. A halt instruction parks the
//   stage in HALTED until reset.
//
// Parameters
//   TIMEOUT           : max WAIT cycles before an access is abandoned (1..15)
//
// Ports
//   clk, rst          : clock, asynchronous active-low reset
//   *_EX_MEM          : instruction fields from the EX/MEM register
//   dmem_req/wr       : data-memory access / write request (combinational)
//   dmem_addr/wdata   : data-memory address / store data (combinational)
//   dmem_ready/rdata  : memory completion strobe and load data
//   stall_mem         : freezes upstream stages (combinational)
//   *_MEM_WB          : MEM/WB register outputs
// -----------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  w1_reg_EX_MEM,
  input  logic        reg_en_EX_MEM,
  input  logic        mem_en_EX_MEM,
  input  logic        mem_wr_EX_MEM,
  input  logic [15:0] writedata_EX_MEM,
  input  logic [15:0] alu_out_EX_MEM,
  input  logic [15:0] r2_EX_MEM,
  input  logic        halt_EX_MEM,
  output logic        dmem_req,
  output logic        dmem_wr,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [15:0] dmem_rdata,
  output logic        stall_mem,
  output logic [2:0]  w1_reg_MEM_WB,
  output logic        reg_en_MEM_WB,
  output logic [15:0] wb_data_MEM_WB,
  output logic        halt_MEM_WB,
  output logic        err_MEM_WB
);

  typedef enum logic [1:0] {IDLE, WAIT, HALTED} state_t;

  localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

  state_t     state;
  logic [3:0] wcnt;

  logic active;       // stage is out of reset and not halted
  logic stall_raw;    // stall before reset gating
  logic timeout_hit;  // last allowed WAIT cycle expired without ready
  logic is_load;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise a latch is inferred.
  always_comb begin
    active      = rst && (state != HALTED);
    is_load     = mem_en_EX_MEM && !mem_wr_EX_MEM;
    timeout_hit = (state == WAIT) && !dmem_ready && (wcnt >= TIMEOUT_CNT);
    stall_raw   = 1'b0;
    case (state)
      IDLE:    stall_raw = mem_en_EX_MEM && !dmem_ready;
      WAIT:    stall_raw = !dmem_ready && (wcnt < TIMEOUT_CNT);
      HALTED:  stall_raw = 1'b1;
      default: stall_raw = 1'b0;
    endcase
    // Gating with rst makes the outputs drop the instant reset asserts,
    // rather than waiting for the state register to settle.
    stall_mem  = rst && stall_raw;
    dmem_req   = active && mem_en_EX_MEM;
    dmem_wr    = dmem_req && mem_wr_EX_MEM;
    dmem_addr  = alu_out_EX_MEM;
    dmem_wdata = r2_EX_MEM;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      wcnt           <= 4'd0;
      w1_reg_MEM_WB  <= 3'd0;
      reg_en_MEM_WB  <= 1'b0;
      wb_data_MEM_WB <= 16'h0000;
      halt_MEM_WB    <= 1'b0;
      err_MEM_WB     <= 1'b0;
    end else if (state == HALTED) begin
      // Parked: keep presenting the halt marker with no writeback.
      w1_reg_MEM_WB  <= 3'd0;
      reg_en_MEM_WB  <= 1'b0;
      wb_data_MEM_WB <= 16'h0000;
      halt_MEM_WB    <= 1'b1;
      err_MEM_WB     <= 1'b0;
    end else if (stall_raw) begin
      // Bubble downstream while the access is outstanding.
      w1_reg_MEM_WB  <= 3'd0;
      reg_en_MEM_WB  <= 1'b0;
      wb_data_MEM_WB <= 16'h0000;
      halt_MEM_WB    <= 1'b0;
      err_MEM_WB     <= 1'b0;
      state          <= WAIT;
      wcnt           <= (state == IDLE) ? 4'd1 : wcnt + 4'd1;
    end else begin
      // Capture: normal completion, non-memory op, or timeout abandon.
      w1_reg_MEM_WB <= w1_reg_EX_MEM;
      halt_MEM_WB   <= halt_EX_MEM;
      if (timeout_hit) begin
        reg_en_MEM_WB  <= 1'b0;
        wb_data_MEM_WB <= 16'h0000;
        err_MEM_WB     <= 1'b1;
      end else begin
        reg_en_MEM_WB  <= reg_en_EX_MEM;
        wb_data_MEM_WB <= is_load ? dmem_rdata : writedata_EX_MEM;
        err_MEM_WB     <= 1'b0;
      end
      state <= halt_EX_MEM ? HALTED : IDLE;
      wcnt  <= 4'd0;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
//   Directed bench for mem_wb_stage. A behavioural model tracks how many stall
//   cycles the current access has used and whether the stage is parked, and a
//   compare process checks every DUT output against it once per cycle.
//   The directed sequence adds literal expectations for each scenario.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  w1_reg_EX_MEM;
  logic        reg_en_EX_MEM, mem_en_EX_MEM, mem_wr_EX_MEM, halt_EX_MEM;
  logic [15:0] writedata_EX_MEM, alu_out_EX_MEM, r2_EX_MEM;
  logic        dmem_req, dmem_wr, dmem_ready;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall_mem;
  logic [2:0]  w1_reg_MEM_WB;
  logic        reg_en_MEM_WB, halt_MEM_WB, err_MEM_WB;
  logic [15:0] wb_data_MEM_WB;

  always #5 clk = ~clk;

  mem_wb_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk              (clk),
    .rst              (rst),
    .w1_reg_EX_MEM    (w1_reg_EX_MEM),
    .reg_en_EX_MEM    (reg_en_EX_MEM),
    .mem_en_EX_MEM    (mem_en_EX_MEM),
    .mem_wr_EX_MEM    (mem_wr_EX_MEM),
    .writedata_EX_MEM (writedata_EX_MEM),
    .alu_out_EX_MEM   (alu_out_EX_MEM),
    .r2_EX_MEM        (r2_EX_MEM),
    .halt_EX_MEM      (halt_EX_MEM),
    .dmem_req         (dmem_req),
    .dmem_wr          (dmem_wr),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_ready       (dmem_ready),
    .dmem_rdata       (dmem_rdata),
    .stall_mem        (stall_mem),
    .w1_reg_MEM_WB    (w1_reg_MEM_WB),
    .reg_en_MEM_WB    (reg_en_MEM_WB),
    .wb_data_MEM_WB   (wb_data_MEM_WB),
    .halt_MEM_WB      (halt_MEM_WB),
    .err_MEM_WB       (err_MEM_WB)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int stall_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_halted = 1'b0;
  int          m_waited = 0;     // stall cycles already spent on this access
  logic [2:0]  m_w1 = '0;
  logic        m_reg_en = 1'b0, m_halt = 1'b0, m_err = 1'b0;
  logic [15:0] m_wb = '0;
  logic        e_stall, e_req, e_timeout;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        m_halted = 1'b0; m_waited = 0;
        m_w1 = '0; m_reg_en = 1'b0; m_wb = '0; m_halt = 1'b0; m_err = 1'b0;
      end
      e_req = rst && !m_halted && mem_en_EX_MEM;
      if (!rst)                               e_stall = 1'b0;
      else if (m_halted)                      e_stall = 1'b1;
      else if (!mem_en_EX_MEM || dmem_ready)  e_stall = 1'b0;
      else                                    e_stall = (m_waited < TIMEOUT);
      e_timeout = rst && !m_halted && mem_en_EX_MEM && !dmem_ready && (m_waited >= TIMEOUT);

      check("m_stall",  stall_mem,      e_stall);
      check("m_req",    dmem_req,       e_req);
      check("m_wr",     dmem_wr,        e_req && mem_wr_EX_MEM);
      check("m_addr",   dmem_addr,      alu_out_EX_MEM);
      check("m_wdata",  dmem_wdata,     r2_EX_MEM);
      check("m_w1",     w1_reg_MEM_WB,  m_w1);
      check("m_reg_en", reg_en_MEM_WB,  m_reg_en);
      check("m_wb",     wb_data_MEM_WB, m_wb);
      check("m_halt",   halt_MEM_WB,    m_halt);
      check("m_err",    err_MEM_WB,     m_err);
      if (stall_mem) stall_seen++;

      // What the coming edge must load.
      if (rst) begin
        if (m_halted) begin
          m_w1 = '0; m_reg_en = 1'b0; m_wb = '0; m_halt = 1'b1; m_err = 1'b0;
        end else if (e_stall) begin
          m_w1 = '0; m_reg_en = 1'b0; m_wb = '0; m_halt = 1'b0; m_err = 1'b0;
          m_waited++;
        end else begin
          m_w1   = w1_reg_EX_MEM;
          m_halt = halt_EX_MEM;
          if (e_timeout) begin
            m_reg_en = 1'b0; m_wb = '0; m_err = 1'b1;
          end else begin
            m_reg_en = reg_en_EX_MEM;
            m_wb     = (mem_en_EX_MEM && !mem_wr_EX_MEM) ? dmem_rdata : writedata_EX_MEM;
            m_err    = 1'b0;
          end
          m_waited = 0;
          m_halted = halt_EX_MEM;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input logic men, input logic mwr, input logic [2:0] w1,
                        input logic ren, input logic [15:0] wd, input logic [15:0] addr,
                        input logic [15:0] r2, input logic halt, input logic rdy,
                        input logic [15:0] rd);
    mem_en_EX_MEM = men;  mem_wr_EX_MEM = mwr;   w1_reg_EX_MEM = w1;
    reg_en_EX_MEM = ren;  writedata_EX_MEM = wd; alu_out_EX_MEM = addr;
    r2_EX_MEM = r2;       halt_EX_MEM = halt;    dmem_ready = rdy;
    dmem_rdata = rd;
  endtask

  task automatic nop();
    set_in(1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a memory op presented: request must stay low.
    set_in(1'b1, 1'b0, 3'd1, 1'b1, 16'h1111, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    check("rst_stall",  stall_mem, 1'b0);
    check("rst_req",    dmem_req, 1'b0);
    check("rst_reg_en", reg_en_MEM_WB, 1'b0);
    check("rst_wb",     wb_data_MEM_WB, 16'h0000);

    // ALU op
    @(negedge clk); rst = 1'b1;
    set_in(1'b0, 1'b0, 3'd3, 1'b1, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    #3 check("alu_stall", stall_mem, 1'b0);
    @(negedge clk); nop();
    #3;
    check("alu_wb",     wb_data_MEM_WB, 16'h1234);
    check("alu_reg_en", reg_en_MEM_WB, 1'b1);
    check("alu_w1",     w1_reg_MEM_WB, 3'd3);

    // Load with 3 wait cycles; junk rdata while not ready
    @(negedge clk); stall_seen = 0;
    set_in(1'b1, 1'b0, 3'd5, 1'b1, 16'h0000, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'hDEAD);
    #3 check("ld_addr", dmem_addr, 16'h0040);
    repeat (2) begin
      @(negedge clk); #3;
      check("ld_bubble_reg_en", reg_en_MEM_WB, 1'b0);
      check("ld_bubble_wb",     wb_data_MEM_WB, 16'h0000);
    end
    @(negedge clk); dmem_ready = 1'b1; dmem_rdata = 16'hBEEF;
    #3 check("ld_done_stall", stall_mem, 1'b0);
    @(negedge clk); nop();
    #3;
    check("ld_wb",     wb_data_MEM_WB, 16'hBEEF);
    check("ld_reg_en", reg_en_MEM_WB, 1'b1);
    check("ld_w1",     w1_reg_MEM_WB, 3'd5);
    check("ld_stalls", stall_seen, 3);

    // Zero-wait store
    @(negedge clk);
    set_in(1'b1, 1'b1, 3'd2, 1'b0, 16'h5555, 16'h0080, 16'h00AA, 1'b0, 1'b1, 16'h0000);
    #3;
    check("st_wr",    dmem_wr, 1'b1);
    check("st_wdata", dmem_wdata, 16'h00AA);
    check("st_stall", stall_mem, 1'b0);
    @(negedge clk); nop();
    #3;
    check("st_wr_off",  dmem_wr, 1'b0);
    check("st_reg_en",  reg_en_MEM_WB, 1'b0);
    check("st_wb",      wb_data_MEM_WB, 16'h5555);

    // Timeout: ready held low
    @(negedge clk); stall_seen = 0;
    set_in(1'b1, 1'b0, 3'd6, 1'b1, 16'h7777, 16'h0100, 16'h0000, 1'b0, 1'b0, 16'h1111);
    repeat (15) @(negedge clk);
    #3 check("to_last_stall", stall_mem, 1'b0);
    @(negedge clk); nop();
    #3;
    check("to_err",    err_MEM_WB, 1'b1);
    check("to_reg_en", reg_en_MEM_WB, 1'b0);
    check("to_wb",     wb_data_MEM_WB, 16'h0000);
    check("to_w1",     w1_reg_MEM_WB, 3'd6);
    check("to_stalls", stall_seen, 15);
    check("to_idle",   stall_mem, 1'b0);

    // Ready arrives exactly on the timeout cycle: normal completion wins
    @(negedge clk);
    set_in(1'b1, 1'b0, 3'd4, 1'b1, 16'h0000, 16'h0104, 16'h0000, 1'b0, 1'b0, 16'h3333);
    repeat (15) @(negedge clk);
    dmem_ready = 1'b1; dmem_rdata = 16'h2222;
    @(negedge clk); nop();
    #3;
    check("tor_err",    err_MEM_WB, 1'b0);
    check("tor_wb",     wb_data_MEM_WB, 16'h2222);
    check("tor_reg_en", reg_en_MEM_WB, 1'b1);

    // Reset in the middle of WAIT
    @(negedge clk);
    set_in(1'b1, 1'b0, 3'd1, 1'b1, 16'h0000, 16'h0200, 16'h0000, 1'b0, 1'b0, 16'h0000);
    repeat (2) @(negedge clk);
    #1 check("rw_pre_stall", stall_mem, 1'b1);
    rst = 1'b0;
    #2;
    check("rw_stall",  stall_mem, 1'b0);
    check("rw_req",    dmem_req, 1'b0);
    check("rw_reg_en", reg_en_MEM_WB, 1'b0);
    @(negedge clk); rst = 1'b1;
    set_in(1'b0, 1'b0, 3'd4, 1'b1, 16'h4321, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    #3 check("rw_resume_stall", stall_mem, 1'b0);
    @(negedge clk); nop();
    #3;
    check("rw_resume_wb", wb_data_MEM_WB, 16'h4321);
    check("rw_resume_w1", w1_reg_MEM_WB, 3'd4);

    // Halt carried by a load with one wait cycle
    @(negedge clk);
    set_in(1'b1, 1'b0, 3'd7, 1'b1, 16'h0000, 16'h0300, 16'h0000, 1'b1, 1'b0, 16'hDEAD);
    @(negedge clk); dmem_ready = 1'b1; dmem_rdata = 16'hC0DE;
    #3 check("hl_done_stall", stall_mem, 1'b0);
    @(negedge clk);
    set_in(1'b1, 1'b1, 3'd2, 1'b1, 16'h9999, 16'h0400, 16'h0055, 1'b0, 1'b1, 16'h0000);
    #3;
    check("hl_wb",     wb_data_MEM_WB, 16'hC0DE);
    check("hl_halt",   halt_MEM_WB, 1'b1);
    check("hl_stall",  stall_mem, 1'b1);
    check("hl_req",    dmem_req, 1'b0);
    repeat (4) begin
      @(negedge clk); #3;
      check("hd_halt",   halt_MEM_WB, 1'b1);
      check("hd_reg_en", reg_en_MEM_WB, 1'b0);
      check("hd_stall",  stall_mem, 1'b1);
      check("hd_req",    dmem_req, 1'b0);
    end

    // Reset out of HALTED
    @(negedge clk); #1 rst = 1'b0;
    #2;
    check("rh_stall", stall_mem, 1'b0);
    check("rh_halt",  halt_MEM_WB, 1'b0);
    @(negedge clk); rst = 1'b1;
    set_in(1'b0, 1'b0, 3'd2, 1'b1, 16'h0F0F, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    @(negedge clk); nop();
    #3;
    check("rh_wb",   wb_data_MEM_WB, 16'h0F0F);
    check("rh_halt2", halt_MEM_WB, 1'b0);

    @(negedge clk); #4;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum WAIT cycles before a data-memory access is abandoned; legal range 1..15.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have these ports from the EX/MEM register:
- w1_reg_EX_MEM, input, 3 bits: destination register.
- reg_en_EX_MEM, input, 1 bit: register write enable.
- mem_en_EX_MEM, input, 1 bit: memory access requested.
- mem_wr_EX_MEM, input, 1 bit: 1 = store, 0 = load.
- writedata_EX_MEM, input, 16 bits: writeback data for non-load instructions.
- alu_out_EX_MEM, input, 16 bits: memory address.
- r2_EX_MEM, input, 16 bits: store data.
- halt_EX_MEM, input, 1 bit: halt marker.
REQ-005 SHALL have these data-memory ports:
- dmem_req, output, 1 bit: access request.
- dmem_wr, output, 1 bit: write request.
- dmem_addr, output, 16 bits: address.
- dmem_wdata, output, 16 bits: write data.
- dmem_ready, input, 1 bit: access completes this cycle.
- dmem_rdata, input, 16 bits: load data, valid when dmem_ready = 1.
REQ-006 SHALL have port stall_mem, output, 1 bit: freezes all upstream stages and holds the EX/MEM outputs stable.
REQ-007 SHALL have these MEM/WB register outputs:
- w1_reg_MEM_WB, output, 3 bits.
- reg_en_MEM_WB, output, 1 bit.
- wb_data_MEM_WB, output, 16 bits.
- halt_MEM_WB, output, 1 bit.
- err_MEM_WB, output, 1 bit.

Function
REQ-008 SHALL implement the states IDLE, WAIT and HALTED, plus a 4-bit wait counter wcnt.
REQ-009 SHALL drive the memory outputs combinationally:
- dmem_req = mem_en_EX_MEM when in IDLE or WAIT, and 0 when in HALTED.
- dmem_wr = dmem_req & mem_wr_EX_MEM.
- dmem_addr = alu_out_EX_MEM.
- dmem_wdata = r2_EX_MEM.
REQ-010 SHALL handle IDLE as follows:
- mem_en_EX_MEM = 0: stall_mem = 0; the MEM/WB register captures the instruction at the edge.
- mem_en_EX_MEM = 1 and dmem_ready = 1: zero-wait completion; stall_mem = 0; capture at the edge.
- mem_en_EX_MEM = 1 and dmem_ready = 0: stall_mem = 1; next state WAIT; wcnt <= 1.
REQ-011 SHALL handle WAIT as follows:
- dmem_ready = 1: stall_mem = 0; capture at the edge; next state IDLE; wcnt <= 0.
- dmem_ready = 0 and wcnt = TIMEOUT: timeout; stall_mem = 0; capture with err = 1; next state IDLE.
- dmem_ready = 0 and wcnt < TIMEOUT: stall_mem = 1; wcnt <= wcnt + 1.
- If dmem_ready = 1 and wcnt = TIMEOUT occur together, dmem_ready SHALL win (normal completion, err = 0).
REQ-012 On capture, the MEM/WB register SHALL load:
- w1_reg_MEM_WB <= w1_reg_EX_MEM.
- halt_MEM_WB <= halt_EX_MEM.
- wb_data_MEM_WB <= dmem_rdata for a load, writedata_EX_MEM otherwise.
- reg_en_MEM_WB <= reg_en_EX_MEM.
- err_MEM_WB <= 0.
REQ-013 On a timeout capture, the MEM/WB register SHALL load reg_en_MEM_WB = 0, wb_data_MEM_WB = 16'h0000 and err_MEM_WB = 1; other fields as in REQ-012.
REQ-014 On every edge where stall_mem = 1, the MEM/WB register SHALL load a bubble: all outputs 0.
REQ-015 On a capture with halt_EX_MEM = 1, the next state SHALL be HALTED; if mem_en_EX_MEM = 1 on that instruction, its access is performed first.
REQ-016 In HALTED the block SHALL behave as follows:
- stall_mem = 1 and dmem_req = 0.
- The MEM/WB register holds halt_MEM_WB = 1 and reg_en_MEM_WB = 0.
- HALTED is left only by reset.
REQ-017 SHALL sample dmem_rdata only in the completing cycle; rdata in non-ready cycles SHALL be ignored.

Reset
REQ-018 While rst = 0 the block SHALL immediately force state IDLE, wcnt = 0, all MEM/WB outputs 0, stall_mem = 0 and dmem_req = 0, including mid-WAIT or in HALTED.
REQ-019 After rst rises, the first edge SHALL process the instruction then present on the EX/MEM inputs normally.

Verification
REQ-020 The bench SHALL cover an ALU op: mem_en = 0, writedata = 16'h1234, reg_en = 1, w1 = 3 -> next edge wb_data = 16'h1234, reg_en = 1, w1 = 3, stall never asserted.
REQ-021 The bench SHALL cover a load with 3 wait cycles: addr = 16'h0040, ready low 3 cycles then high with rdata = 16'hBEEF -> stall high for exactly 3 cycles, 3 bubbles, then wb_data = 16'hBEEF, reg_en = 1.
REQ-022 The bench SHALL cover a zero-wait store: mem_wr = 1, r2 = 16'h00AA, ready = 1 -> dmem_wr = 1 and dmem_wdata = 16'h00AA for one cycle, stall = 0.
REQ-023 The bench SHALL cover a timeout with TIMEOUT = 15: load with ready held low -> stall high 15 cycles, then capture with err = 1, reg_en = 0, wb_data = 0, state IDLE.
REQ-024 The bench SHALL cover halt: halt_EX_MEM = 1 -> halt_MEM_WB = 1, stall_mem = 1 and dmem_req = 0 held indefinitely, even with mem_en = 1 presented.
REQ-025 The bench SHALL cover reset in WAIT: drop rst in the middle of WAIT -> dmem_req and stall fall without a clock edge, outputs 0, and normal operation resumes after rst rises.
